menu_controller: RTL and testbench
==================================

# menu_controller

Upstream stage of the on-screen menu text renderer. Turns five raw push-button inputs into the menu state the renderer draws: cursor position (`menu_sel`), three phase durations, and the simulation run state. It synchronises and debounces the buttons, edge-detects presses, and runs a cursor navigator and a Play/Pause/Stop state machine. All outputs are registered and hold steady between presses.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz). Must be ≥ 2.
- `MIN_DUR`, default 1: lower saturation bound for every duration.
- `MAX_DUR`, default 99: upper saturation bound. Must be ≤ 99, because the renderer shows two digits.
- `DEF_GREEN`, default 10: reset value of `green_duration`.
- `DEF_YELLOW`, default 3: reset value of `yellow_duration`.
- `DEF_RED`, default 2: reset value of `red_holding`.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `rst_n` input 1: reset, asynchronous, active-low.
- `btn_up` input 1: raw button, asynchronous to `clk`.
- `btn_down` input 1: raw button, asynchronous.
- `btn_left` input 1: raw button, asynchronous.
- `btn_right` input 1: raw button, asynchronous.
- `btn_center` input 1: raw button, asynchronous.
- `menu_sel` output 4: cursor item. Values are 1 Green, 2 Yellow, 3 Red hold, 6 Play, 7 Pause, 8 Stop.
- `green_duration` output 8: green phase length in seconds.
- `yellow_duration` output 8: yellow phase length in seconds.
- `red_holding` output 8: all-red hold length in seconds.
- `run_state` output 2: simulation state. 00 STOPPED, 01 PLAYING, 10 PAUSED. 11 is never driven.
- `sim_clear` output 1: one-cycle pulse on entry into STOPPED from PLAYING or PAUSED.

## Operation

Button front end (identical per button):
- Two-flop synchroniser.
- Debouncer: a counter increments while the synchronised sample differs from the debounced level, and clears to 0 when they are equal.
- When the counter reaches `DEBOUNCE_CYCLES-1` with the sample still differing, the debounced level takes the sample value and the counter clears.
- Registered press pulse: high for exactly one cycle after a debounced 0→1 transition. Release produces no pulse.
- Holding a button produces one pulse only.

Event arbitration:
- Only one press is acted on per cycle.
- Priority: center > up > down > right > left. Lower-priority pulses in the same cycle are dropped.

Navigation (`menu_sel`):
- Cycle order is 1, 2, 3, 6, 7, 8.
- Down moves to the next item in the order; 8 wraps to 1.
- Up moves to the previous item; 1 wraps to 8.
- `menu_sel` never holds any value outside {1, 2, 3, 6, 7, 8}.

Value editing:
- Applies only when `menu_sel` ∈ {1, 2, 3} and `run_state` ≠ PLAYING.
- Right adds 1 to the selected duration, saturating at `MAX_DUR`.
- Left subtracts 1, saturating at `MIN_DUR`.
- Left or Right with the cursor on items 6–8, or while PLAYING, has no effect.
- Arithmetic is 8-bit unsigned. No wrap is possible.

Run FSM (advanced by Center only):
- Center on item 6 (Play): STOPPED → PLAYING, PAUSED → PLAYING. PLAYING stays PLAYING.
- Center on item 7 (Pause): PLAYING → PAUSED. All other states are unchanged.
- Center on item 8 (Stop): any state → STOPPED. `sim_clear` pulses only if the previous state was not STOPPED.
- Center on items 1–3: no effect.

## Timing

Reset values (applied asynchronously, released on the next edge):
- `menu_sel` = 1.
- Durations = `DEF_GREEN`, `DEF_YELLOW`, `DEF_RED`.
- `run_state` = 00.
- `sim_clear` = 0.
- All synchronisers, debounced levels, counters and press pulses = 0.

Latency:
- A raw 0→1 held stable changes the affected output register exactly `DEBOUNCE_CYCLES + 4` rising edges after the first edge that samples it high.
- Breakdown: 2 for the synchroniser, `DEBOUNCE_CYCLES` for the debouncer, 1 for the press pulse, 1 for the output update.
- `sim_clear` is asserted in the same cycle `run_state` becomes 00.

Glitch handling:
- A glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronisation produces no pulse, and its counter returns to 0.

Reset mid-operation:
- Asserting `rst_n` mid-debounce or mid-pulse discards the pending press.
- A button still held through reset release is treated as a new press once debounced, because the debounced level reset to 0.

## Test plan

All scenarios use `DEBOUNCE_CYCLES` = 4.

- **Reset:** assert `rst_n`=0 mid-sim, then release. Required: `menu_sel`=1, durations 10/3/2, `run_state`=00, `sim_clear`=0. The first press after reset updates its output at edge 8.
- **Navigation wrap:** press Down 6 times. Required: `menu_sel` sequence 2, 3, 6, 7, 8, 1. Then press Up once from 1. Required: `menu_sel`=8.
- **Saturation:** on item 1, press Right 95 times from 10. Required: `green_duration`=99 and stays there. On item 2, press Left 5 times from 3. Required: `yellow_duration`=1.
- **Run FSM:**
  - Play → `run_state`=01.
  - Right on item 1 → green unchanged.
  - Pause → 10.
  - Play → 01.
  - Stop → 00 with exactly one `sim_clear` cycle.
  - Stop again → no `sim_clear`.
- **Debounce and priority:**
  - 3-cycle pulse on `btn_down` → no change.
  - Held button → exactly one step.
  - Up and Down presses landing in the same cycle → only Up applied: `menu_sel` 1 → 8.

Source files
------------

// File: rtl/menu_controller.sv
// Front end of the on-screen menu: debounces five push buttons and turns the
// resulting presses into cursor position, three phase durations and run state.
module menu_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MIN_DUR         = 1,
    parameter int MAX_DUR         = 99,
    parameter int DEF_GREEN       = 10,
    parameter int DEF_YELLOW      = 3,
    parameter int DEF_RED         = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic [3:0] menu_sel,
    output logic [7:0] green_duration,
    output logic [7:0] yellow_duration,
    output logic [7:0] red_holding,
    output logic [1:0] run_state,
    output logic       sim_clear
);

    localparam int NB = 5;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] MIN_B = 8'(MIN_DUR);
    localparam logic [7:0] MAX_B = 8'(MAX_DUR);

    // Bit positions inside the packed button vector
    localparam int B_LEFT   = 0;
    localparam int B_RIGHT  = 1;
    localparam int B_DOWN   = 2;
    localparam int B_UP     = 3;
    localparam int B_CENTER = 4;

    typedef enum logic [1:0] {
        RUN_STOPPED = 2'b00,
        RUN_PLAYING = 2'b01,
        RUN_PAUSED  = 2'b10
    } run_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_CENTER,
        EV_UP,
        EV_DOWN,
        EV_RIGHT,
        EV_LEFT
    } event_e;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] level_q, level_d, level_prev_q;
    logic [NB-1:0] press_q, press_d;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];

    assign btn_raw = {btn_center, btn_up, btn_down, btn_right, btn_left};

    // Counter runs only while the synchronised sample disagrees with the
    // accepted level; any agreement throws the partial count away.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        press_d = level_q & ~level_prev_q;
    end

    // NOTE: every flop, including the counter array, is reset; a stale
    // count surviving reset would let a half-debounced press leak through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            press_q      <= '0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    event_e ev;

    always_comb begin
        ev = EV_NONE;
        if      (press_q[B_CENTER]) ev = EV_CENTER;
        else if (press_q[B_UP])     ev = EV_UP;
        else if (press_q[B_DOWN])   ev = EV_DOWN;
        else if (press_q[B_RIGHT])  ev = EV_RIGHT;
        else if (press_q[B_LEFT])   ev = EV_LEFT;
    end

    function automatic logic [3:0] next_sel(input logic [3:0] s);
        case (s)
            4'd1:    return 4'd2;
            4'd2:    return 4'd3;
            4'd3:    return 4'd6;
            4'd6:    return 4'd7;
            4'd7:    return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [3:0] prev_sel(input logic [3:0] s);
        case (s)
            4'd2:    return 4'd1;
            4'd3:    return 4'd2;
            4'd6:    return 4'd3;
            4'd7:    return 4'd6;
            4'd8:    return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] bump(input logic [7:0] v, input logic inc);
        if (inc) return (v >= MAX_B) ? MAX_B : v + 8'd1;
        else     return (v <= MIN_B) ? MIN_B : v - 8'd1;
    endfunction

    logic [3:0] sel_q, sel_d;
    logic [7:0] green_q, green_d, yellow_q, yellow_d, red_q, red_d;
    run_e       run_q, run_d;
    logic       sim_clear_q, sim_clear_d;

    // NOTE: every _d gets its default before the case so no path infers a latch.
    always_comb begin
        sel_d       = sel_q;
        green_d     = green_q;
        yellow_d    = yellow_q;
        red_d       = red_q;
        run_d       = run_q;
        sim_clear_d = 1'b0;
        case (ev)
            EV_CENTER: begin
                case (sel_q)
                    4'd6: run_d = RUN_PLAYING;
                    4'd7: if (run_q == RUN_PLAYING) run_d = RUN_PAUSED;
                    4'd8: begin
                        run_d       = RUN_STOPPED;
                        sim_clear_d = (run_q != RUN_STOPPED);
                    end
                    default: ;
                endcase
            end
            EV_UP:   sel_d = prev_sel(sel_q);
            EV_DOWN: sel_d = next_sel(sel_q);
            EV_RIGHT, EV_LEFT: begin
                if (run_q != RUN_PLAYING) begin
                    case (sel_q)
                        4'd1:    green_d  = bump(green_q,  ev == EV_RIGHT);
                        4'd2:    yellow_d = bump(yellow_q, ev == EV_RIGHT);
                        4'd3:    red_d    = bump(red_q,    ev == EV_RIGHT);
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= 4'd1;
            green_q     <= 8'(DEF_GREEN);
            yellow_q    <= 8'(DEF_YELLOW);
            red_q       <= 8'(DEF_RED);
            run_q       <= RUN_STOPPED;
            sim_clear_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            green_q     <= green_d;
            yellow_q    <= yellow_d;
            red_q       <= red_d;
            run_q       <= run_d;
            sim_clear_q <= sim_clear_d;
        end
    end

    assign menu_sel        = sel_q;
    assign green_duration  = green_q;
    assign yellow_duration = yellow_q;
    assign red_holding     = red_q;
    assign run_state       = run_q;
    assign sim_clear       = sim_clear_q;

endmodule

// File: tb/tb_menu_controller.sv
// Self-checking bench for menu_controller with a short debounce window,
// compared against an abstract menu model kept in the bench.
module tb_menu_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic       btn_right = 1'b0, btn_center = 1'b0;
    logic [3:0] menu_sel;
    logic [7:0] green_duration, yellow_duration, red_holding;
    logic [1:0] run_state;
    logic       sim_clear;

    menu_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .btn_up          (btn_up),
        .btn_down        (btn_down),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .btn_center      (btn_center),
        .menu_sel        (menu_sel),
        .green_duration  (green_duration),
        .yellow_duration (yellow_duration),
        .red_holding     (red_holding),
        .run_state       (run_state),
        .sim_clear       (sim_clear)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] M_C = 5'b10000;
    localparam logic [4:0] M_U = 5'b01000;
    localparam logic [4:0] M_D = 5'b00100;
    localparam logic [4:0] M_R = 5'b00010;
    localparam logic [4:0] M_L = 5'b00001;

    int n_checks = 0;
    int n_pass   = 0;
    int clear_cnt = 0;

    // Reference model: cursor as an index into the item list, durations as
    // plain integers, run state 0 stopped / 1 playing / 2 paused.
    int order [6] = '{1, 2, 3, 6, 7, 8};
    int idx;
    int dur [3];
    int run;

    wire [29:0] dut_vec = {menu_sel, green_duration, yellow_duration, red_holding, run_state};

    function automatic logic [29:0] model_vec();
        return {4'(order[idx]), 8'(dur[0]), 8'(dur[1]), 8'(dur[2]), 2'(run)};
    endfunction

    task automatic model_reset();
        idx = 0;
        dur = '{10, 3, 2};
        run = 0;
    endtask

    task automatic model_apply(input logic [4:0] m, output int clr);
        int v;
        clr = 0;
        if (m[4]) begin
            if (order[idx] == 6) run = 1;
            else if (order[idx] == 7 && run == 1) run = 2;
            else if (order[idx] == 8) begin
                clr = (run != 0) ? 1 : 0;
                run = 0;
            end
        end else if (m[3]) begin
            idx = (idx + 5) % 6;
        end else if (m[2]) begin
            idx = (idx + 1) % 6;
        end else if (m[1] || m[0]) begin
            if (idx < 3 && run != 1) begin
                v = dur[idx] + (m[1] ? 1 : -1);
                if (v > 99) v = 99;
                if (v < 1) v = 1;
                dur[idx] = v;
            end
        end
    endtask

    task automatic drive(input logic [4:0] m);
        {btn_center, btn_up, btn_down, btn_right, btn_left} = m;
    endtask

    // Press, hold, release and settle; reports sim_clear pulses seen and expected.
    task automatic step(input logic [4:0] m, input int hold, output int clr_dut, output int clr_exp);
        int start;
        @(negedge clk);
        start = clear_cnt;
        drive(m);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        drive(5'b0);
        repeat (12) @(posedge clk);
        #1;
        clr_dut = clear_cnt - start;
        model_apply(m, clr_exp);
    endtask

    task automatic goto_item(input int target);
        int a, b;
        for (int k = 0; k < 6 && order[idx] != target; k++) step(M_D, 7, a, b);
    endtask

    always @(negedge clk) begin
        if (rst_n && sim_clear) begin
            clear_cnt++;
            n_checks++;
            if (run_state !== 2'b00)
                $display("FAIL sim_clear_state: run_state=%b while sim_clear high, want 00", run_state);
            else n_pass++;
        end
    end

    task automatic test_reset();
        int a, b;
        drive(5'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec !== model_vec() || sim_clear !== 1'b0)
            $display("FAIL reset_values: got %h clr=%b, want %h clr=0", dut_vec, sim_clear, model_vec());
        else n_pass++;

        // First press after reset lands on edge 8, not 7
        @(negedge clk);
        drive(M_D);
        repeat (7) @(posedge clk);
        #1;
        n_checks++;
        if (menu_sel !== 4'd1) $display("FAIL latency_edge7: menu_sel=%0d, want 1", menu_sel);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (menu_sel !== 4'd2) $display("FAIL latency_edge8: menu_sel=%0d, want 2", menu_sel);
        else n_pass++;
        @(negedge clk);
        drive(5'b0);
        repeat (12) @(posedge clk);
        model_apply(M_D, a);

        step(M_R, 8, a, b);
        n_checks++;
        if (dut_vec !== model_vec()) $display("FAIL pre_reset_edit: got %h, want %h", dut_vec, model_vec());
        else n_pass++;

        // Reset while a press is still being debounced
        @(negedge clk);
        drive(M_D);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drive(5'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (15) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec !== model_vec() || sim_clear !== 1'b0)
            $display("FAIL reset_mid_press: got %h clr=%b, want %h clr=0", dut_vec, sim_clear, model_vec());
        else n_pass++;
    endtask

    task automatic test_nav_wrap();
        int exp_seq [6] = '{2, 3, 6, 7, 8, 1};
        int a, b;
        goto_item(1);
        for (int k = 0; k < 6; k++) begin
            step(M_D, 7, a, b);
            n_checks++;
            if (menu_sel !== 4'(exp_seq[k])) $display("FAIL nav_down_%0d: menu_sel=%0d, want %0d", k, menu_sel, exp_seq[k]);
            else n_pass++;
        end
        step(M_U, 7, a, b);
        n_checks++;
        if (menu_sel !== 4'd8) $display("FAIL nav_up_wrap: menu_sel=%0d, want 8", menu_sel);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int a, b;
        goto_item(1);
        for (int k = 0; k < 95; k++) step(M_R, 7, a, b);
        n_checks++;
        if (green_duration !== 8'd99) $display("FAIL green_sat_max: green=%0d, want 99", green_duration);
        else n_pass++;
        step(M_R, 7, a, b);
        n_checks++;
        if (green_duration !== 8'd99) $display("FAIL green_sat_hold: green=%0d, want 99", green_duration);
        else n_pass++;
        goto_item(2);
        for (int k = 0; k < 5; k++) step(M_L, 7, a, b);
        n_checks++;
        if (yellow_duration !== 8'd1) $display("FAIL yellow_sat_min: yellow=%0d, want 1", yellow_duration);
        else n_pass++;
        n_checks++;
        if (dut_vec !== model_vec()) $display("FAIL saturation_state: got %h, want %h", dut_vec, model_vec());
        else n_pass++;
    endtask

    task automatic test_run_fsm();
        int c, e;
        goto_item(1);
        step(M_L, 7, c, e);
        goto_item(6);
        step(M_C, 7, c, e);
        n_checks++;
        if (run_state !== 2'b01 || c != 0) $display("FAIL fsm_play: run=%b clr=%0d, want 01 clr=0", run_state, c);
        else n_pass++;
        goto_item(1);
        step(M_R, 7, c, e);
        n_checks++;
        if (green_duration !== 8'd98) $display("FAIL fsm_edit_locked: green=%0d, want 98", green_duration);
        else n_pass++;
        goto_item(7);
        step(M_C, 7, c, e);
        n_checks++;
        if (run_state !== 2'b10) $display("FAIL fsm_pause: run=%b, want 10", run_state);
        else n_pass++;
        goto_item(6);
        step(M_C, 7, c, e);
        n_checks++;
        if (run_state !== 2'b01) $display("FAIL fsm_resume: run=%b, want 01", run_state);
        else n_pass++;
        goto_item(8);
        step(M_C, 7, c, e);
        n_checks++;
        if (run_state !== 2'b00 || c != 1) $display("FAIL fsm_stop: run=%b clr=%0d, want 00 clr=1", run_state, c);
        else n_pass++;
        step(M_C, 7, c, e);
        n_checks++;
        if (run_state !== 2'b00 || c != 0) $display("FAIL fsm_stop_again: run=%b clr=%0d, want 00 clr=0", run_state, c);
        else n_pass++;
        n_checks++;
        if (dut_vec !== model_vec()) $display("FAIL fsm_state: got %h, want %h", dut_vec, model_vec());
        else n_pass++;
    endtask

    task automatic test_debounce_priority();
        int c, e;
        @(negedge clk);
        drive(M_D);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(5'b0);
        repeat (15) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec !== model_vec()) $display("FAIL glitch_ignored: got %h, want %h", dut_vec, model_vec());
        else n_pass++;
        step(M_D, 60, c, e);
        n_checks++;
        if (dut_vec !== model_vec()) $display("FAIL held_one_step: got %h, want %h", dut_vec, model_vec());
        else n_pass++;
        goto_item(1);
        step(M_U | M_D, 8, c, e);
        n_checks++;
        if (menu_sel !== 4'd8) $display("FAIL priority_up_over_down: menu_sel=%0d, want 8", menu_sel);
        else n_pass++;
    endtask

    task automatic test_random();
        int c, e;
        logic [4:0] m;
        for (int k = 0; k < 40; k++) begin
            m = 5'($urandom_range(1, 31));
            step(m, int'($urandom_range(7, 15)), c, e);
            n_checks++;
            if (dut_vec !== model_vec() || c != e)
                $display("FAIL random_%0d mask=%b: got %h clr=%0d, want %h clr=%0d", k, m, dut_vec, c, model_vec(), e);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nav_wrap();
        test_saturation();
        test_run_fsm();
        test_debounce_priority();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
